// File: rtl/aes_pkg.sv
// Shared AES MixColumns types: column/state containers, FSM encoding and the
// GF(2^8) doubling helper.
package aes_pkg;

  localparam int NUM_COLS = 4;

  typedef logic [31:0] col_t;
  // Element [3] is column0 (bits [127:96]), element [0] is column3.
  typedef logic [NUM_COLS-1:0][31:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/mix_col_unit.sv
// One forward MixColumns column, purely combinational.
// Byte order inside a column is {row0, row1, row2, row3} from MSB down.
module mix_col_unit
  import aes_pkg::*;
(
  input  col_t col_in,
  output col_t col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] d0, d1, d2, d3;

  assign {a0, a1, a2, a3} = col_in;

  assign d0 = xtime(a0);
  assign d1 = xtime(a1);
  assign d2 = xtime(a2);
  assign d3 = xtime(a3);

  // 3x is expressed as xtime(x) ^ x.
  assign col_out = {d0 ^ d1 ^ a1 ^ a2 ^ a3,
                    a0 ^ d1 ^ d2 ^ a2 ^ a3,
                    a0 ^ a1 ^ d2 ^ d3 ^ a3,
                    d0 ^ a0 ^ a1 ^ a2 ^ d3};

endmodule

// File: rtl/mix_column_iter.sv
// Iterative AES MixColumns: transforms COLS_PER_CYCLE columns per cycle in a
// working register, then presents the registered result with valid/ready.
module mix_column_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(NUM_COLS - COLS_PER_CYCLE);

  fsm_e       state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  state_t     work_q, work_d, work_calc;
  state_t     out_q, out_d;

  col_t unit_in  [COLS_PER_CYCLE];
  col_t unit_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    logic [1:0] pos;
    assign pos        = cnt_q + 2'(g);
    assign unit_in[g] = work_q[2'd3 - pos];
    mix_col_unit u_col (
      .col_in  (unit_in[g]),
      .col_out (unit_out[g])
    );
  end

  // Results overwrite their source columns; untouched columns pass through.
  always_comb begin
    work_calc = work_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      work_calc[2'd3 - (cnt_q + 2'(k))] = unit_out[k];
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    out_d    = out_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        work_d = work_calc;
        cnt_d  = cnt_q + STEP;
        if (cnt_q == LAST) begin
          out_d   = work_calc;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            work_d  = in_data;
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: the data registers are reset too, so a reset mid-transform
      // leaves nothing of the discarded state visible on out_data.
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  assign out_data  = out_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mix_column_iter.sv
// Self-checking bench: three instances (1, 2, 4 columns per cycle) driven from
// a vector table, directed stall/reset sequences and random round trips.
module tb_mix_column_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         out_ready [3];
  logic [127:0] in_data   [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [127:0] out_data  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_column_iter #(.COLS_PER_CYCLE(1 << g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] sb [$];

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: circulant GF(2^8) matrix product, coefficient for
  // output row r and input row j is coef[(j - r) mod 4].
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] mat(input logic [127:0] s, input logic [7:0] c0,
                                       input logic [7:0] c1, input logic [7:0] c2,
                                       input logic [7:0] c3);
    logic [7:0]   coef [4];
    logic [127:0] res = '0;
    logic [7:0]   acc;
    coef = '{c0, c1, c2, c3};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(coef[(j - r) & 3], s[127 - 32*c - 8*j -: 8]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    return mat(s, 8'd2, 8'd3, 8'd1, 8'd1);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return mat(s, 8'd14, 8'd11, 8'd13, 8'd9);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic compare_output(input int idx, input string name);
    logic [127:0] exp;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 128'd1, 128'd0);
    end else begin
      exp = sb.pop_front();
      check(name, out_data[idx], exp);
    end
  endtask

  task automatic wait_out(input int idx, input int want, input string name);
    int lat = 0;
    while (!out_valid[idx] && lat < 16) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 128'(lat), 128'(want));
  endtask

  // One full transaction on an idle instance; in_data is scrambled after
  // acceptance to show it is ignored while in_ready is low.
  task automatic run_one(input int idx, input logic [127:0] din,
                         input logic [127:0] exp, input string name);
    check({name, "_in_ready"}, 128'(in_ready[idx]), 128'd1);
    in_valid[idx] = 1'b1;
    in_data[idx]  = din;
    sb.push_back(exp);
    tick();
    in_data[idx]  = rnd128();
    check({name, "_busy"}, 128'({busy[idx], out_valid[idx], in_ready[idx]}), 128'b100);
    wait_out(idx, 4 >> idx, name);
    in_valid[idx] = 1'b0;
    compare_output(idx, name);
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         vecs [6];
    logic [127:0] held, a_exp, b_exp, din;
    int           idx;

    vecs[0] = '{128'hdb135345_01010101_01010101_01010101,
                128'h8e4da1bc_01010101_01010101_01010101};
    vecs[1] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
                128'h046681e5_e0cb199a_48f8d37a_2806264c};
    vecs[2] = '{128'hf20a225c_c6c6c6c6_d4d4d4d5_2d26314c,
                128'h9fdc589d_c6c6c6c6_d5d5d7d6_4d7ebdf8};
    vecs[3] = '{128'h0, 128'h0};
    vecs[4] = '{{4{32'hffffffff}}, {4{32'hffffffff}}};
    vecs[5] = '{128'h2d26314c_d4d4d4d5_c6c6c6c6_f20a225c,
                128'h4d7ebdf8_d5d5d7d6_c6c6c6c6_9fdc589d};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      in_data[i]   = '0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_out_data_%0d", i), out_data[i], 128'd0);
      check($sformatf("reset_flags_%0d", i),
            128'({out_valid[i], busy[i], in_ready[i]}), 128'b001);
    end
    tick();
    tick();
    rst_n = 1'b1;

    // Table vectors through every width; latency 4, 2, 1.
    for (int i = 0; i < 3; i++)
      for (int v = 0; v < 6; v++)
        run_one(i, vecs[v].din, vecs[v].exp, $sformatf("vec%0d_cpc%0d", v, 1 << i));

    // Output stall with pending input, then back-to-back capture.
    a_exp = vecs[1].exp;
    b_exp = vecs[2].exp;
    in_valid[0] = 1'b1;
    in_data[0]  = vecs[1].din;
    sb.push_back(a_exp);
    tick();
    in_valid[0] = 1'b0;
    wait_out(0, 4, "stall_a");
    held = out_data[0];
    in_valid[0] = 1'b1;
    in_data[0]  = vecs[2].din;
    for (int c = 0; c < 10; c++) begin
      check("stall_in_ready", 128'(in_ready[0]), 128'd0);
      check("stall_out_data", out_data[0], held);
      tick();
    end
    check("stall_out_valid", 128'(out_valid[0]), 128'd1);
    compare_output(0, "stall_a");
    out_ready[0] = 1'b1;
    #1;
    check("b2b_in_ready", 128'(in_ready[0]), 128'd1);
    sb.push_back(b_exp);
    tick();
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    check("b2b_capture", 128'({out_valid[0], busy[0]}), 128'b01);
    wait_out(0, 4, "b2b_b");
    compare_output(0, "b2b_b");
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;

    // Reset in the second CALC cycle discards the in-flight state.
    in_valid[0] = 1'b1;
    in_data[0]  = vecs[0].din;
    tick();
    in_valid[0] = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midcalc_rst_out_data", out_data[0], 128'd0);
    check("midcalc_rst_flags", 128'({out_valid[0], busy[0], in_ready[0]}), 128'b001);
    tick();
    rst_n = 1'b1;
    sb.delete();
    for (int c = 0; c < 8; c++) begin
      check("post_rst_no_valid", 128'(out_valid[0]), 128'd0);
      tick();
    end

    // Input presented right at reset release is taken on the first edge.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_one(0, vecs[1].din, vecs[1].exp, "first_after_rst");

    // Random states: scoreboard against the model, then the inverse round trip.
    for (int i = 0; i < 1000; i++) begin
      idx = i % 3;
      din = rnd128();
      run_one(idx, din, fwd_mix(din), "rand");
      check("rand_roundtrip", inv_mix(out_data[idx]), din);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_column_iter.md
MIX_COLUMN_ITER -- requirements
Module: mix_column_iter

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1: columns transformed per compute cycle; legal values 1, 2, 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_data carries a state to transform.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  128  AES state, column-major; [127:96]=column0 {row0,row1,row2,row3}, down to [31:0]=column3.
REQ-007 out_valid  output  1  out_data holds a completed result.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  128  forward MixColumns result, same byte layout as in_data.
REQ-010 busy  output  1  high in CALC or DONE.

Function
REQ-011 SHALL compute forward AES MixColumns per column: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3; GF(2^8), poly 0x11B.
REQ-012 xtime(x) SHALL equal (x<<1)[7:0] XOR (0x1B when x[7]=1); 3x = xtime(x)^x.
REQ-013 FSM states SHALL be IDLE, CALC, DONE.
REQ-014 Handshake: a transfer occurs only on a cycle with valid and ready both high.
REQ-015 IDLE: in_ready=1; on in transfer, SHALL capture in_data into a working register, clear column counter, go to CALC.
REQ-016 CALC: in_ready=0; each cycle SHALL transform COLS_PER_CYCLE columns starting at counter value, writing results in place; counter increments by COLS_PER_CYCLE.
REQ-017 When the last column group is written, the FSM SHALL go to DONE; counter wraps to 0.
REQ-018 Latency: out_valid SHALL rise exactly 4/COLS_PER_CYCLE cycles after the accepting edge (4, 2, 1).
REQ-019 DONE: out_valid=1; out_data SHALL stay stable until an out transfer.
REQ-020 DONE with out_ready=0: in_ready=0; no input accepted.
REQ-021 DONE with out_ready=1: in_ready SHALL equal 1; a simultaneous in transfer captures new data and goes to CALC; otherwise go to IDLE.
REQ-022 out_valid SHALL be 0 in IDLE and CALC; out_data SHALL hold the last result outside DONE.
REQ-023 in_valid/in_data changes while in_ready=0 SHALL have no effect.
REQ-024 Column processing order SHALL be column0 first; intermediate register contents are not observable.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, counter=0, working register=0, out_valid=0, busy=0, in_ready=1, out_data=0.
REQ-026 Reset mid-CALC or mid-DONE SHALL discard the in-flight state; no out_valid pulse after deassertion without a new input.
REQ-027 First input SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package aes_pkg SHALL hold the xtime function, the 32-bit column type, the 128-bit state type and the FSM state enum.
REQ-029 Sub-module mix_col_unit SHALL implement one column combinationally (32-bit in/out); COLS_PER_CYCLE instances are generated.
REQ-030 Registered outputs only; no combinational path from in_data to out_data.

Verification
REQ-031 Column db135345 in column0, other columns 01010101 -> out column0 8e4da1bc, others 01010101, out_valid after 4 cycles.
REQ-032 State d4bf5d30 e0b452ae b84111f1 1e2798e5 -> 046681e5 e0cb199a 48f8d37a 2806264c, all COLS_PER_CYCLE values; latencies 4/2/1.
REQ-033 Columns f20a225c, c6c6c6c6, d4d4d4d5, 2d26314c -> 9fdc589d, c6c6c6c6, d5d5d7d6, 4d7ebdf8.
REQ-034 out_ready held 0 for 10 cycles in DONE with in_valid=1 -> out_data stable, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back capture, next result after 4 cycles.
REQ-035 rst_n pulsed low in cycle 2 of CALC -> outputs zero immediately, in_ready=1, no out_valid until a new input.
REQ-036 1000 random states through mix_column_iter then inv_mix_column -> output equals input.
